// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle for the sequential ALU / mul-div execute unit.
`timescale 1ns/1ps
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_muldiv;
  logic [3:0]      req_fn;
  logic [XLEN-1:0] req_in1;
  logic [XLEN-1:0] req_in2;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_cmp;

  modport master (
    output req_valid, req_muldiv, req_fn, req_in1, req_in2, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_cmp
  );

  modport slave (
    input  req_valid, req_muldiv, req_fn, req_in1, req_in2, kill, resp_ready,
    output req_ready, resp_valid, resp_data, resp_cmp
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Execute unit: single-cycle ALU plus iterative RV-M multiply/divide behind valid/ready.
// Build option MULDIV_EARLY_OUT_EN: plain MUL leaves early once the remaining multiplier bits are zero.
`timescale 1ns/1ps
module alu_muldiv_seq #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_muldiv_seq_if.slave io
);
  localparam int LOGX  = $clog2(XLEN);
  localparam int CW    = LOGX + 1;
  localparam int MSTEP = XLEN / MUL_UNROLL;

  typedef enum logic [2:0] {IDLE, MUL, DIV, DIV_FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]        fn_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q, quo_q, rem_q, dsr_q, data_q;
  logic              neg_q_q, neg_r_q, cmp_q;
  logic              accept;

  assign accept = io.req_valid && (state_q == IDLE);

  // ALU
  logic [LOGX-1:0] shamt;
  logic [XLEN-1:0] alu_data;
  logic            alu_cmp, lt_s, lt_u;

  always_comb begin
    shamt    = io.req_in2[LOGX-1:0];
    lt_s     = $signed(io.req_in1) < $signed(io.req_in2);
    lt_u     = io.req_in1 < io.req_in2;
    alu_data = '0;
    alu_cmp  = 1'b0;
    case (io.req_fn)
      4'd0:  alu_data = io.req_in1 + io.req_in2;
      4'd1:  alu_data = io.req_in1 << shamt;
      4'd2:  alu_cmp  = (io.req_in1 == io.req_in2);
      4'd3:  alu_cmp  = (io.req_in1 != io.req_in2);
      4'd4:  alu_data = io.req_in1 ^ io.req_in2;
      4'd5:  alu_data = io.req_in1 >> shamt;
      4'd6:  alu_data = io.req_in1 | io.req_in2;
      4'd7:  alu_data = io.req_in1 & io.req_in2;
      4'd10: alu_data = io.req_in1 - io.req_in2;
      4'd11: alu_data = $signed(io.req_in1) >>> shamt;
      4'd12: begin alu_cmp = lt_s; alu_data = {{(XLEN-1){1'b0}}, lt_s}; end
      4'd13: alu_cmp  = !lt_s;
      4'd14: begin alu_cmp = lt_u; alu_data = {{(XLEN-1){1'b0}}, lt_u}; end
      4'd15: alu_cmp  = !lt_u;
      default: ;
    endcase
  end

  // Multiplier step. The accept edge already retires the first MUL_UNROLL bits,
  // so the op finishes on exactly the MSTEP-th edge.
  logic [1:0]        st_fn;
  logic [CW-1:0]     st_cnt;
  logic [2*XLEN-1:0] st_acc, st_mcand, mul_acc, mul_mcand;
  logic [XLEN-1:0]   st_mplier, mul_mplier, mul_res;
  logic              a_sgn, mul_early, mul_last;

  always_comb begin
    a_sgn = (io.req_fn[1:0] == 2'd1) || (io.req_fn[1:0] == 2'd2);
    if (state_q == IDLE) begin
      st_fn     = io.req_fn[1:0];
      st_cnt    = '0;
      st_acc    = '0;
      st_mcand  = {{XLEN{a_sgn & io.req_in1[XLEN-1]}}, io.req_in1};
      st_mplier = io.req_in2;
    end else begin
      st_fn     = fn_q;
      st_cnt    = cnt_q;
      st_acc    = acc_q;
      st_mcand  = mcand_q;
      st_mplier = mplier_q;
    end
    mul_acc = st_acc;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      if (st_mplier[j]) begin
        // signed multiplier: the top bit carries negative weight
        if (st_fn == 2'd1 && (int'(st_cnt) * MUL_UNROLL + j == XLEN - 1))
          mul_acc = mul_acc - (st_mcand << j);
        else
          mul_acc = mul_acc + (st_mcand << j);
      end
    end
    mul_mcand  = st_mcand << MUL_UNROLL;
    mul_mplier = st_mplier >> MUL_UNROLL;
    mul_res    = (st_fn == 2'd0) ? mul_acc[XLEN-1:0] : mul_acc[2*XLEN-1:XLEN];
`ifdef MULDIV_EARLY_OUT_EN
    mul_early  = (st_fn == 2'd0) && (mul_mplier == '0);
`else
    mul_early  = 1'b0;
`endif
    mul_last   = mul_early || (st_cnt == CW'(MSTEP - 1));
  end

  // Restoring divider on magnitudes; the first iteration also runs on the accept edge.
  logic            dv_sgn, dz, ovf, div_fast, ge;
  logic [XLEN-1:0] mag1, mag2, st_quo, st_rem, st_dsr;
  logic [XLEN-1:0] div_quo, div_rem, diff, fast_data, quo_fix, rem_fix;
  logic [XLEN:0]   trial;

  always_comb begin
    dv_sgn   = !io.req_fn[0];
    mag1     = (dv_sgn && io.req_in1[XLEN-1]) ? -io.req_in1 : io.req_in1;
    mag2     = (dv_sgn && io.req_in2[XLEN-1]) ? -io.req_in2 : io.req_in2;
    dz       = (io.req_in2 == '0);
    ovf      = dv_sgn && (io.req_in1 == {1'b1, {(XLEN-1){1'b0}}}) && (&io.req_in2);
    div_fast = dz || ovf;
    if (dz) fast_data = io.req_fn[1] ? io.req_in1 : '1;
    else    fast_data = io.req_fn[1] ? '0 : io.req_in1;
    if (state_q == IDLE) begin
      st_quo = mag1;
      st_rem = '0;
      st_dsr = mag2;
    end else begin
      st_quo = quo_q;
      st_rem = rem_q;
      st_dsr = dsr_q;
    end
    trial   = {st_rem, st_quo[XLEN-1]};
    ge      = trial >= {1'b0, st_dsr};
    diff    = trial[XLEN-1:0] - st_dsr;
    div_rem = ge ? diff : trial[XLEN-1:0];
    div_quo = {st_quo[XLEN-2:0], ge};
    quo_fix = neg_q_q ? -quo_q : quo_q;
    rem_fix = neg_r_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (!io.req_muldiv || io.req_fn[3]) state_d = DONE;
        else if (!io.req_fn[2])             state_d = mul_last ? DONE : MUL;
        else if (div_fast)                  state_d = DONE;
        else                                state_d = DIV;
      end
      MUL:     if (mul_last) state_d = DONE;
      DIV:     if (cnt_q == CW'(XLEN - 1)) state_d = DIV_FIX;
      DIV_FIX: state_d = DONE;
      DONE:    if (io.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.kill && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fn_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      data_q   <= '0;
      cmp_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          fn_q   <= io.req_fn[1:0];
          data_q <= '0;
          cmp_q  <= 1'b0;
          if (!io.req_muldiv) begin
            data_q <= alu_data;
            cmp_q  <= alu_cmp;
          end else if (io.req_fn[3]) begin
          end else if (!io.req_fn[2]) begin
            acc_q    <= mul_acc;
            mcand_q  <= mul_mcand;
            mplier_q <= mul_mplier;
            cnt_q    <= CW'(1);
            data_q   <= mul_res;
          end else if (div_fast) begin
            data_q <= fast_data;
          end else begin
            quo_q   <= div_quo;
            rem_q   <= div_rem;
            dsr_q   <= mag2;
            neg_q_q <= dv_sgn && (io.req_in1[XLEN-1] ^ io.req_in2[XLEN-1]);
            neg_r_q <= dv_sgn && io.req_in1[XLEN-1];
            cnt_q   <= CW'(1);
          end
        end
        MUL: begin
          acc_q    <= mul_acc;
          mcand_q  <= mul_mcand;
          mplier_q <= mul_mplier;
          cnt_q    <= cnt_q + CW'(1);
          data_q   <= mul_res;
        end
        DIV: begin
          quo_q <= div_quo;
          rem_q <= div_rem;
          cnt_q <= cnt_q + CW'(1);
        end
        DIV_FIX: data_q <= fn_q[1] ? rem_fix : quo_fix;
        default: ;
      endcase
      if (state_d == IDLE) cnt_q <= '0;
    end
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.resp_valid = (state_q == DONE);
  assign io.resp_data  = (state_q == DONE) ? data_q : '0;
  assign io.resp_cmp   = (state_q == DONE) ? cmp_q : 1'b0;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: arithmetic reference model plus literal pins.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_muldiv_seq_if #(.XLEN(32)) io();
  alu_muldiv_seq #(.XLEN(32), .MUL_UNROLL(1)) dut (.clock(clock), .reset_n(reset_n), .io(io));

  int checks = 0, failures = 0, done_cnt = 0;
  // expectations pinned by hand for the current op
  bit          lit_en = 1'b0;
  logic [31:0] lit_data = '0;
  logic        lit_cmp = 1'b0;
  int          lit_lat = 0;

  function automatic void model(input bit md, input logic [3:0] fn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] d, output logic c,
                                output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int hb;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    d = '0; c = 1'b0; lat = 1; p = '0; hb = -1;
    if (!md) begin
      case (fn)
        4'd0:  d = a + b;
        4'd1:  d = a << b[4:0];
        4'd2:  c = (a == b);
        4'd3:  c = (a != b);
        4'd4:  d = a ^ b;
        4'd5:  d = a >> b[4:0];
        4'd6:  d = a | b;
        4'd7:  d = a & b;
        4'd10: d = a - b;
        4'd11: d = 32'($signed(a) >>> b[4:0]);
        4'd12: begin c = (sa < sb); d = {31'b0, c}; end
        4'd13: c = (sa >= sb);
        4'd14: begin c = (ua < ub); d = {31'b0, c}; end
        4'd15: c = (ua >= ub);
        default: ;
      endcase
    end else if (fn < 4'd4) begin
      lat = 32;
      case (fn[1:0])
        2'd1:    p = 64'(sa * sb);
        2'd2:    p = 64'(sa * ub);
        default: p = 64'(ua * ub);
      endcase
      d = (fn == 4'd0) ? p[31:0] : p[63:32];
`ifdef MULDIV_EARLY_OUT_EN
      if (fn == 4'd0) begin
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        lat = (hb < 0) ? 1 : hb + 1;
      end
`endif
    end else if (fn < 4'd8) begin
      lat = 33;
      if (b == 32'd0) begin
        lat = 1; d = fn[1] ? a : 32'hFFFF_FFFF;
      end else if (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lat = 1; d = fn[1] ? 32'd0 : a;
      end else begin
        case (fn[1:0])
          2'd0: d = 32'(sa / sb);
          2'd1: d = 32'(ua / ub);
          2'd2: d = 32'(sa % sb);
          2'd3: d = 32'(ua % ub);
        endcase
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: one negedge sample per cycle against the model.
  bit          active = 1'b0, seen = 1'b0;
  int          edges = 0, m_lat = 0;
  logic [31:0] m_data = '0;
  logic        m_cmp = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready", io.req_ready, 1);
      chk("rst_resp_valid", io.resp_valid, 0);
      chk("rst_resp_data", io.resp_data, 0);
      chk("rst_resp_cmp", io.resp_cmp, 0);
      active = 1'b0;
    end else begin
      if (!active) begin
        chk("idle_resp_valid", io.resp_valid, 0);
        chk("idle_req_ready", io.req_ready, 1);
      end else begin
        edges++;
        chk("resp_valid", io.resp_valid, edges >= m_lat);
        chk("busy_req_ready", io.req_ready, 0);
        if (io.resp_valid) begin
          chk("resp_data", io.resp_data, m_data);
          chk("resp_cmp", io.resp_cmp, m_cmp);
          if (lit_en && !seen) begin
            chk("lit_data", io.resp_data, lit_data);
            chk("lit_cmp", io.resp_cmp, lit_cmp);
            chk("lit_latency", edges, lit_lat);
          end
          seen = 1'b1;
        end
        if (io.kill || (io.resp_valid && io.resp_ready)) begin
          active = 1'b0;
          done_cnt++;
        end
      end
      if (!active && io.req_valid && io.req_ready) begin
        model(io.req_muldiv, io.req_fn, io.req_in1, io.req_in2, m_data, m_cmp, m_lat);
        active = 1'b1; edges = 0; seen = 1'b0;
      end
    end
  end

  task automatic issue(input bit md, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    io.req_valid = 1'b1; io.req_muldiv = md; io.req_fn = fn; io.req_in1 = a; io.req_in2 = b;
    @(posedge clock); #1;
    // scramble inputs after accept; the unit must have registered them
    io.req_valid = 1'b0; io.req_muldiv = 1'($urandom); io.req_fn = 4'($urandom);
    io.req_in1 = $urandom; io.req_in2 = $urandom;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 300) begin @(posedge clock); #1; n++; end
    if (done_cnt == base) begin
      $display("FAIL response_timeout actual=none required=response");
      $fatal(1, "no response");
    end
  endtask

  task automatic op(input bit md, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                    input bit le, input logic [31:0] ld, input logic lc, input int ll);
    int base;
    lit_en = le; lit_data = ld; lit_cmp = lc; lit_lat = ll;
    base = done_cnt;
    issue(md, fn, a, b);
    wait_done(base);
  endtask

  initial begin
    int base, n;
    io.req_valid = 1'b0; io.req_muldiv = 1'b0; io.req_fn = '0;
    io.req_in1 = '0; io.req_in2 = '0; io.kill = 1'b0; io.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // ALU
    op(0, 4'd10, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 0, 1);
    op(0, 4'd14, 32'd5, 32'd7, 1, 32'd1, 1, 1);
    op(0, 4'd11, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 0, 1);
    op(0, 4'd1, 32'd1, 32'd35, 1, 32'd8, 0, 1);
    op(0, 4'd2, 32'd3, 32'd3, 1, 32'd0, 1, 1);
    op(0, 4'd12, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1, 1);
    op(0, 4'd13, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, 1);
    op(0, 4'd15, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1, 1);
    op(0, 4'd8, 32'd9, 32'd9, 1, 32'd0, 0, 1);
    op(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0);
    op(0, 4'd3, 32'd4, 32'd5, 0, 0, 0, 0);
    op(0, 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0, 0);
    op(0, 4'd5, 32'h8000_0010, 32'd4, 0, 0, 0, 0);
    op(0, 4'd6, 32'h1200_0000, 32'h0034_0000, 0, 0, 0, 0);
    op(0, 4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0, 0);

    // multiply
    op(1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, 0, 32);
    op(1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0, 32);
    op(1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 32);
    op(1, 4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0);
    op(1, 4'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0);
    op(1, 4'd0, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 0);

    // divide
    op(1, 4'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 0, 33);
    op(1, 4'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 0, 33);
    op(1, 4'd5, 32'd7, 32'd0, 1, 32'hFFFF_FFFF, 0, 1);
    op(1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 1);
    op(1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0, 1);
    op(1, 4'd7, 32'd7, 32'd0, 1, 32'd7, 0, 1);
    op(1, 4'd5, 32'd100, 32'd7, 1, 32'd14, 0, 33);
    op(1, 4'd7, 32'd100, 32'd7, 1, 32'd2, 0, 33);
    op(1, 4'd4, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0);
    op(1, 4'd9, 32'd5, 32'd5, 1, 32'd0, 0, 1);

    // backpressure: hold the result 10 cycles
    lit_en = 1'b1; lit_data = 32'd12; lit_cmp = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    lit_lat = 3;
`else
    lit_lat = 32;
`endif
    base = done_cnt;
    io.resp_ready = 1'b0;
    issue(1, 4'd0, 32'd3, 32'd4);
    n = 0;
    while (!io.resp_valid && n < 100) begin @(posedge clock); #1; n++; end
    repeat (10) @(posedge clock);
    #1 io.resp_ready = 1'b1;
    wait_done(base);

    // kill on edge 10 of a divide
    lit_en = 1'b0;
    base = done_cnt;
    issue(1, 4'd4, 32'd100, 32'd3);
    repeat (8) @(posedge clock);
    #1 io.kill = 1'b1;
    @(posedge clock);
    #1 io.kill = 1'b0;
    wait_done(base);
    op(0, 4'd0, 32'd1, 32'd1, 1, 32'd2, 0, 1);

    // reset in the middle of a multiply
    lit_en = 1'b0;
    issue(1, 4'd0, 32'd123, 32'hFFFF_0000);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
    op(1, 4'd0, 32'd3, 32'd2, 1, 32'd6, 0, 2);
`else
    op(1, 4'd0, 32'd3, 32'd2, 1, 32'd6, 0, 32);
`endif

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
